power_pattern_gen: RTL and testbench
====================================

Name: power_pattern_gen

Overview:
Upstream stimulus stage for the power-test adder.
- Generates the two 7-bit operand streams that drive the adder's operand inputs.
- Patterns have controlled switching activity, so per-pattern power can be measured on silicon.
- Also provides a registered expected sum and a pattern count for a downstream checker.

Parameters:
WIDTH, 7, operand width in bits.
SEED, 16'hACE1, LFSR value loaded at reset; must be non-zero.
CNT_W, 16, width of the pattern counter.

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst  input  1  reset, synchronous and active-high.
ena  input  1  global enable; low pauses generation.
start  input  1  start request; sampled in IDLE only.
stop  input  1  stop request; sampled in RUN only.
mode  input  2  pattern mode; latched at start.
burst_len  input  8  number of patterns per burst; 0 means continuous; latched at start.
op_a  output  WIDTH  operand A (registered).
op_b  output  WIDTH  operand B (registered).
exp_sum  output  WIDTH+1  zero-extended op_a+op_b (registered, same cycle as operands).
op_valid  output  1  operands are valid this cycle.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse at end of burst.
pat_cnt  output  CNT_W  patterns emitted since last start; saturates at all-ones.

Behaviour:
Reset (rst high at an edge):
- State becomes IDLE; LFSR is loaded with SEED.
- op_a, op_b, exp_sum, pat_cnt, busy and done all become 0; op_valid is 0.
- Reset mid-burst aborts immediately; no done pulse is issued.

States: IDLE, RUN, DONE.
- IDLE -> RUN: start high at an edge.
  - mode and burst_len are latched; remaining is loaded with burst_len; pat_cnt is cleared.
  - The first pattern is loaded into op_a/op_b/exp_sum.
  - Latency: start is sampled in cycle N; the first pattern appears in cycle N+1.
  - stop is ignored in IDLE.
- op_valid = (state==RUN) & ena. It is the only output not taken directly from a register.
- RUN, op_valid high:
  - The displayed pattern counts as emitted: pat_cnt increments.
  - The next pattern loads at the edge.
  - If burst_len is non-zero, remaining decrements.
- RUN, ena low: all registers hold; no advance, no count, no decrement.
- RUN -> DONE: at an edge where either condition holds:
  - stop is high (the current pattern is counted if op_valid is high); or
  - op_valid is high and remaining==1 with burst_len non-zero.
- stop has priority; stop together with the final pattern yields a single DONE.
- start is ignored in RUN and DONE; mode and burst_len changes mid-run are ignored.
- DONE:
  - done=1, busy=0, op_a=op_b=0, exp_sum=0 (operands go quiet).
  - pat_cnt holds its final value.
  - Next edge: DONE -> IDLE unconditionally.

Pattern modes (the first pattern of a burst is listed first):
- 0 QUIET: op_a=op_b=0 on every pattern (baseline power).
- 1 WALK:
  - op_a is one-hot: 7'h01, 7'h02, ..., 7'h40, then wraps to 7'h01.
  - op_b = ~op_a.
  - The walk restarts at 7'h01 on every start.
- 2 LFSR:
  - 16-bit Galois LFSR, right-shift; if lsb=1, then lfsr = (lfsr>>1) ^ 16'hB400.
  - Each pattern uses op_a=lfsr[6:0] and op_b=lfsr[14:8]; the LFSR steps once per emitted pattern.
  - The LFSR is not reseeded on start; only rst reseeds it.
- 3 MAXTOG: alternates (op_a=7'h7F, op_b=7'h00) and (op_a=7'h00, op_b=7'h7F), starting with 7F/00.

Arithmetic: exp_sum = {1'b0,op_a} + {1'b0,op_b}, with no truncation.

Test Plan:
- Reset: after rst, all outputs are 0, busy=0, op_valid=0; start asserted while rst is high has no effect.
- Mode 1, burst_len=9, ena=1:
  - op_a = 01,02,04,08,10,20,40,01,02; op_b = 7E,7D,7B,77,6F,5F,3F,7E,7D; exp_sum=7F on each.
  - done pulses in the cycle after the 9th pattern; pat_cnt=9; busy falls with done.
- Mode 2, burst_len=2, first burst after reset:
  - Pattern 1: (op_a=61, op_b=2C, exp_sum=08D).
  - Pattern 2: (op_a=70, op_b=62, exp_sum=0D2).
  - Then done.
- Mode 3, burst_len=0:
  - Operands alternate 7F/00, 00/7F indefinitely.
  - stop asserted during the 5th valid cycle gives DONE next, pat_cnt=5, operands forced to 0.
- Mode 1, burst_len=4, ena low for 3 cycles after the 2nd pattern:
  - During the pause op_valid=0 and op_a holds 02.
  - On resume the sequence continues 02,04,08 valid; exactly 4 valid cycles in total; one done.
- Corner cases:
  - start and stop high together in IDLE: the burst starts.
  - stop on the last pattern of burst_len=1: a single done pulse.
  - rst high mid-burst: IDLE next cycle with no done pulse.

Source files
------------

// File: rtl/power_pattern_gen.sv
// Operand pattern source for the power-test adder: quiet, walking-one, LFSR and
// max-toggle streams with a registered expected sum and an emitted-pattern count.
//
// state  | meaning
// IDLE   | waiting for start; operands parked at zero
// RUN    | presenting patterns; one advances per cycle while ena is high
// DONE   | one-cycle end-of-burst marker; operands forced to zero
module power_pattern_gen #(
  parameter int          WIDTH = 7,
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ena,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [1:0]       i_mode,
  input  logic [7:0]       i_burst_len,
  output logic [WIDTH-1:0] o_op_a,
  output logic [WIDTH-1:0] o_op_b,
  output logic [WIDTH:0]   o_exp_sum,
  output logic             o_op_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_pat_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] MODE_QUIET  = 2'd0;
  localparam logic [1:0] MODE_WALK   = 2'd1;
  localparam logic [1:0] MODE_LFSR   = 2'd2;
  localparam logic [1:0] MODE_MAXTOG = 2'd3;

  localparam logic [WIDTH-1:0] L_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [1:0]       r_mode;
  logic [15:0]      r_lfsr;
  logic [7:0]       r_remaining;
  logic             r_burst_nz;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH:0]   r_exp_sum;
  logic [CNT_W-1:0] r_pat_cnt;
  logic             r_busy;
  logic             r_done;

  logic             w_emit;
  logic             w_last;
  logic [15:0]      w_lfsr_step;
  logic [WIDTH-1:0] w_first_a;
  logic [WIDTH-1:0] w_first_b;
  logic [WIDTH-1:0] w_next_a;
  logic [WIDTH-1:0] w_next_b;
  logic [WIDTH-1:0] w_walk_rot;

  assign w_emit = (r_state == S_RUN) & i_ena;
  assign w_last = w_emit & r_burst_nz & (r_remaining == 8'd1);

  always_comb begin
    w_lfsr_step = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    w_walk_rot  = {r_op_a[WIDTH-2:0], r_op_a[WIDTH-1]};

    w_first_a = '0;
    w_first_b = '0;
    case (i_mode)
      MODE_WALK:   begin w_first_a = L_ONE; w_first_b = ~L_ONE; end
      MODE_LFSR:   begin w_first_a = r_lfsr[WIDTH-1:0]; w_first_b = r_lfsr[WIDTH+7:8]; end
      MODE_MAXTOG: begin w_first_a = '1; w_first_b = '0; end
      default:     begin w_first_a = '0; w_first_b = '0; end
    endcase

    // Successors derive from what is on the bus now, so a pause simply holds it.
    w_next_a = '0;
    w_next_b = '0;
    case (r_mode)
      MODE_WALK:   begin w_next_a = w_walk_rot; w_next_b = ~w_walk_rot; end
      MODE_LFSR:   begin w_next_a = w_lfsr_step[WIDTH-1:0]; w_next_b = w_lfsr_step[WIDTH+7:8]; end
      MODE_MAXTOG: begin w_next_a = r_op_b; w_next_b = r_op_a; end
      default:     begin w_next_a = '0; w_next_b = '0; end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_mode      <= MODE_QUIET;
      r_lfsr      <= SEED;
      r_remaining <= '0;
      r_burst_nz  <= 1'b0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_exp_sum   <= '0;
      r_pat_cnt   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state     <= S_RUN;
            r_busy      <= 1'b1;
            r_mode      <= i_mode;
            r_remaining <= i_burst_len;
            r_burst_nz  <= |i_burst_len;
            r_pat_cnt   <= '0;
            r_op_a      <= w_first_a;
            r_op_b      <= w_first_b;
            r_exp_sum   <= {1'b0, w_first_a} + {1'b0, w_first_b};
          end
        end
        S_RUN: begin
          if (w_emit) begin
            r_pat_cnt <= (&r_pat_cnt) ? r_pat_cnt : r_pat_cnt + 1'b1;
            if (r_mode == MODE_LFSR) r_lfsr <= w_lfsr_step;
            if (r_burst_nz) r_remaining <= r_remaining - 8'd1;
          end
          if (i_stop || w_last) begin
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_exp_sum <= '0;
          end else if (w_emit) begin
            r_op_a    <= w_next_a;
            r_op_b    <= w_next_b;
            r_exp_sum <= {1'b0, w_next_a} + {1'b0, w_next_b};
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_op_a     = r_op_a;
  assign o_op_b     = r_op_b;
  assign o_exp_sum  = r_exp_sum;
  assign o_op_valid = w_emit;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_pat_cnt  = r_pat_cnt;

endmodule

// File: tb/tb_power_pattern_gen.sv
// Scoreboard bench for power_pattern_gen: bursts push expected patterns and done
// markers into a queue; a negedge monitor pops and compares what the DUT presents.
module tb_power_pattern_gen;

  localparam int          WIDTH = 7;
  localparam int          CNT_W = 16;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic             clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_ena = 1'b0;
  logic             i_start = 1'b0;
  logic             i_stop = 1'b0;
  logic [1:0]       i_mode = 2'd0;
  logic [7:0]       i_burst_len = 8'd0;
  logic [WIDTH-1:0] o_op_a;
  logic [WIDTH-1:0] o_op_b;
  logic [WIDTH:0]   o_exp_sum;
  logic             o_op_valid;
  logic             o_busy;
  logic             o_done;
  logic [CNT_W-1:0] o_pat_cnt;

  always #5 clk = ~clk;

  power_pattern_gen #(.WIDTH(WIDTH), .SEED(SEED), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_ena(i_ena), .i_start(i_start), .i_stop(i_stop),
    .i_mode(i_mode), .i_burst_len(i_burst_len), .o_op_a(o_op_a), .o_op_b(o_op_b),
    .o_exp_sum(o_exp_sum), .o_op_valid(o_op_valid), .o_busy(o_busy), .o_done(o_done),
    .o_pat_cnt(o_pat_cnt)
  );

  typedef struct {
    bit         is_done;
    logic [6:0] a;
    logic [6:0] b;
    logic [15:0] cnt;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  logic [15:0] m_lfsr = SEED;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  // k-th emitted pattern of a burst, straight from the mode definitions
  task automatic push_patterns(input int mode, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.is_done = 1'b0;
      e.cnt = 16'(k);
      case (mode)
        1: begin e.a = 7'(1 << (k % 7)); e.b = ~e.a; end
        2: begin e.a = m_lfsr[6:0]; e.b = m_lfsr[14:8]; m_lfsr = lfsr_next(m_lfsr); end
        3: begin e.a = (k % 2 == 0) ? 7'h7F : 7'h00; e.b = ~e.a; end
        default: begin e.a = 7'h00; e.b = 7'h00; end
      endcase
      q.push_back(e);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_op_a"}, 32'(o_op_a), 32'h0);
    check({tag, "_op_b"}, 32'(o_op_b), 32'h0);
    check({tag, "_exp_sum"}, 32'(o_exp_sum), 32'h0);
    check({tag, "_pat_cnt"}, 32'(o_pat_cnt), 32'h0);
    check({tag, "_busy"}, 32'(o_busy), 32'h0);
    check({tag, "_done"}, 32'(o_done), 32'h0);
    check({tag, "_valid"}, 32'(o_op_valid), 32'h0);
  endtask

  task automatic run_burst(input int mode, input int len, input int stop_at, input int rst_at,
                           input int pause_pct, input int pause_after, input bit stop_with_start);
    int n_emit;
    int emitted;
    int cyc;
    int paused;
    bit finished;
    exp_t d;
    if (rst_at > 0) n_emit = rst_at;
    else if (len == 0) n_emit = stop_at;
    else if (stop_at > 0 && stop_at < len) n_emit = stop_at;
    else n_emit = len;
    push_patterns(mode, n_emit);
    if (rst_at == 0) begin
      d.is_done = 1'b1; d.a = 7'h00; d.b = 7'h00; d.cnt = 16'(n_emit);
      q.push_back(d);
    end
    i_start = 1'b1;
    i_mode = 2'(mode);
    i_burst_len = 8'(len);
    i_stop = stop_with_start;
    i_ena = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    i_start = 1'($urandom_range(0, 1));
    i_mode = 2'($urandom);
    i_burst_len = 8'($urandom);
    i_stop = 1'b0;
    emitted = 0; cyc = 0; paused = 0; finished = 1'b0;
    while (!finished) begin
      if (pause_after > 0 && emitted == pause_after && paused < 3) begin
        i_ena = 1'b0;
        paused++;
      end else if ($urandom_range(0, 99) < pause_pct) i_ena = 1'b0;
      else i_ena = 1'b1;
      if (i_ena) begin
        emitted++;
        if (rst_at > 0 && emitted == rst_at) i_rst = 1'b1;
        else if (stop_at > 0 && emitted == stop_at) i_stop = 1'b1;
        if (emitted == n_emit) finished = 1'b1;
      end
      @(posedge clk); #1;
      i_stop = 1'b0;
      cyc++;
      if (cyc > 400) begin
        check("burst_cycle_budget", 32'(cyc), 32'd400);
        finished = 1'b1;
      end
    end
    i_start = 1'b0;
    i_ena = 1'($urandom_range(0, 1));
    if (rst_at > 0) begin
      i_rst = 1'b0;
      m_lfsr = SEED;
      check_idle_outputs("rst_mid_burst");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (o_op_valid || o_done) begin
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: valid=%0b done=%0b with nothing expected at %0t",
                     o_op_valid, o_done, $time);
          end else begin
            mon_e = q.pop_front();
            check("done_vs_valid", 32'(o_done), 32'(mon_e.is_done));
            if (mon_e.is_done) begin
              check("done_busy", 32'(o_busy), 32'h0);
              check("done_valid", 32'(o_op_valid), 32'h0);
              check("done_operands", {9'h0, o_op_a, o_op_b, o_exp_sum}, 32'h0);
              check("done_pat_cnt", 32'(o_pat_cnt), 32'(mon_e.cnt));
            end else begin
              check("op_a", 32'(o_op_a), 32'(mon_e.a));
              check("op_b", 32'(o_op_b), 32'(mon_e.b));
              check("exp_sum", 32'(o_exp_sum), 32'(mon_e.a) + 32'(mon_e.b));
              check("pat_cnt", 32'(o_pat_cnt), 32'(mon_e.cnt));
              check("run_busy", 32'(o_busy), 32'h1);
            end
          end
        end else if (o_busy && q.size() > 0 && !q[0].is_done) begin
          check("pause_hold_a", 32'(o_op_a), 32'(q[0].a));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode;
    int len;
    int stop_at;
    i_rst = 1'b1;
    i_start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;
    i_start = 1'b0;
    m_lfsr = SEED;
    mon_en = 1'b1;
    check_idle_outputs("after_reset");
    @(posedge clk); #1;
    check("start_during_rst_busy", 32'(o_busy), 32'h0);

    run_burst(1, 9, 0, 0, 0, 0, 1'b0);
    run_burst(2, 2, 0, 0, 0, 0, 1'b0);
    run_burst(3, 0, 5, 0, 0, 0, 1'b0);
    run_burst(1, 4, 0, 0, 0, 1, 1'b0);
    run_burst(0, 3, 0, 0, 10, 0, 1'b1);
    run_burst(3, 1, 1, 0, 0, 0, 1'b0);
    run_burst(2, 0, 0, 4, 0, 0, 1'b0);
    run_burst(2, 3, 0, 0, 0, 0, 1'b0);

    repeat (25) begin
      mode = $urandom_range(0, 3);
      len = $urandom_range(0, 12);
      if (len == 0) stop_at = $urandom_range(1, 12);
      else if ($urandom_range(0, 2) == 0) stop_at = $urandom_range(1, len + 1);
      else stop_at = 0;
      run_burst(mode, len, stop_at, 0, 20, 0, 1'($urandom_range(0, 1)));
    end
    run_burst(1, 0, 0, 3, 20, 0, 1'b0);
    run_burst(2, 5, 0, 0, 20, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
